// File: rtl/power_on_reset_gen.sv
// power_on_reset_gen: holds a registered active-high reset for RST_CYCLES clocks after configuration or a request
module power_on_reset_gen #(
  parameter int RST_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o = 1'b1,
  output logic rst_n_o = 1'b0
);
  localparam int CNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(RST_CYCLES);
  logic [CNT_W-1:0] cnt = '0;
  logic [CNT_W-1:0] nxt;
  assign nxt = cnt + 1'b1;
  // counter saturates at MAX so the reset never re-asserts on its own
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt     <= '0;
      rst_o   <= 1'b1;
      rst_n_o <= 1'b0;
    end else if (cnt != MAX) begin
      cnt     <= nxt;
      rst_o   <= nxt != MAX;
      rst_n_o <= nxt == MAX;
    end else begin
      rst_o   <= 1'b0;
      rst_n_o <= 1'b1;
    end
endmodule

// File: tb/tb_power_on_reset_gen.sv
// tb_power_on_reset_gen: directed checks of power-up, request, re-trigger, glitch, minimum and long-hold behaviour
module tb_power_on_reset_gen;
  logic clk_i = 1'b0;
  logic rst4 = 1'b0, rst8 = 1'b0, rst1 = 1'b0, rst16 = 1'b0;
  logic o4, n4, o8, n8, o1, n1, o16, n16;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  power_on_reset_gen #(.RST_CYCLES(4))  dut4  (.clk_i(clk_i), .rst_i(rst4),  .rst_o(o4),  .rst_n_o(n4));
  power_on_reset_gen #(.RST_CYCLES(8))  dut8  (.clk_i(clk_i), .rst_i(rst8),  .rst_o(o8),  .rst_n_o(n8));
  power_on_reset_gen #(.RST_CYCLES(1))  dut1  (.clk_i(clk_i), .rst_i(rst1),  .rst_o(o1),  .rst_n_o(n1));
  power_on_reset_gen #(.RST_CYCLES(16)) dut16 (.clk_i(clk_i), .rst_i(rst16), .rst_o(o16), .rst_n_o(n16));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic e4, e8, e1, e16;
    #1;
    checks++;
    if ({o4, n4, o8, n8, o1, n1, o16, n16} !== 8'b10101010) begin
      errors++;
      $display("FAIL reset_t0: got %b expected 10101010", {o4, n4, o8, n8, o1, n1, o16, n16});
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      e4 = e < 4; e8 = e < 8; e1 = 1'b0; e16 = e < 16;
      checks++;
      if ({o4, n4, o8, n8, o1, n1, o16, n16} !== {e4, ~e4, e8, ~e8, e1, ~e1, e16, ~e16}) begin
        errors++;
        $display("FAIL powerup edge %0d: got %b expected %b", e, {o4, n4, o8, n8, o1, n1, o16, n16},
                 {e4, ~e4, e8, ~e8, e1, ~e1, e16, ~e16});
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({o4, n4, o16, n16} !== 4'b0101) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b expected 0101", i, {o4, n4, o16, n16});
      end
    end
  endtask

  task automatic test_request();
    logic e;
    rst4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o4, n4} !== 2'b10) begin
        errors++;
        $display("FAIL request hold %0d: got %b expected 10", i, {o4, n4});
      end
    end
    rst4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = k < 4;
      checks++;
      if ({o4, n4} !== {e, ~e}) begin
        errors++;
        $display("FAIL request release %0d: got %b expected %b", k, {o4, n4}, {e, ~e});
      end
    end
  endtask

  task automatic test_glitch();
    logic e;
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      e = k < 4;
      checks++;
      if ({o4, n4} !== {e, ~e}) begin
        errors++;
        $display("FAIL glitch %0d: got %b expected %b", k, {o4, n4}, {e, ~e});
      end
    end
  endtask

  task automatic test_retrigger();
    logic e;
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      rst8 = k == 5;
      tick();
      e = k < 13;
      checks++;
      if ({o8, n8} !== {e, ~e}) begin
        errors++;
        $display("FAIL retrigger %0d: got %b expected %b", k, {o8, n8}, {e, ~e});
      end
      if (k == 5) begin
        checks++;
        if (dut8.cnt !== 4'd0) begin
          errors++;
          $display("FAIL retrigger_cnt: got %0d expected 0", dut8.cnt);
        end
      end
    end
    rst8 = 1'b0;
  endtask

  task automatic test_min();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    checks++;
    if ({o1, n1} !== 2'b10) begin
      errors++;
      $display("FAIL min_high: got %b expected 10", {o1, n1});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({o1, n1} !== 2'b01) begin
        errors++;
        $display("FAIL min_low %0d: got %b expected 01", k, {o1, n1});
      end
    end
  endtask

  task automatic test_long_hold();
    logic e;
    rst16 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({o16, n16} !== 2'b10) begin
        errors++;
        $display("FAIL long_hold %0d: got %b expected 10", i, {o16, n16});
      end
    end
    rst16 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      e = k < 16;
      checks++;
      if ({o16, n16} !== {e, ~e}) begin
        errors++;
        $display("FAIL long_release %0d: got %b expected %b", k, {o16, n16}, {e, ~e});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_request();
    test_glitch();
    test_retrigger();
    test_min();
    test_long_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
